// File: rtl/axi_llc_pkg.sv
// Shared LLC types and helpers for the data-way SRAM responder and its scrubber.
package axi_llc_pkg;

    typedef struct packed {
        int unsigned IndexLength;
        int unsigned BlockOffsetLength;
        int unsigned BlockSize;
        int unsigned DataEccGranularity;
    } llc_cfg_t;

    // Small default geometry: 16 words of 64 bits, 16-bit parity granules.
    localparam llc_cfg_t LlcDefaultCfg = '{
        IndexLength:        32'd3,
        BlockOffsetLength:  32'd1,
        BlockSize:          32'd64,
        DataEccGranularity: 32'd16
    };

    // Read latency of the data macro in cycles.
    localparam int unsigned DataMacroLatency = 1;

    // Widest granule the parity helper can fold.
    localparam int unsigned MaxGranW = 1024;

    typedef enum logic [0:0] {
        SCRUB_IDLE,
        SCRUB_SCAN
    } scrub_state_e;

    // Even parity over the low gran_w bits of a granule.
    function automatic logic granule_parity(input logic [MaxGranW-1:0] gran,
                                            input int unsigned gran_w);
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < MaxGranW; i++) begin
            if (i < gran_w) p = p ^ gran[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/axi_llc_data_scrubber.sv
// Background scrub sequencer: walks every address once per trigger, using idle
// port cycles and stealing one grant after ScrubMaxWait starved cycles.
module axi_llc_data_scrubber
    import axi_llc_pkg::*;
#(
    parameter int unsigned AW           = 4,
    parameter int unsigned ScrubMaxWait = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          trigger_i,
    input  logic          ram_req_i,
    output logic          gnt_o,
    output logic          scrub_rd_o,
    output logic [AW-1:0] scrub_addr_o,
    output logic          busy_o
);

    localparam int unsigned CntW = (ScrubMaxWait > 0) ? $clog2(ScrubMaxWait + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ScrubMaxWait);

    scrub_state_e  state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          steal;

    // State, scan address and starvation counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SCRUB_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, scrub read slot selection and grant stealing.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        steal      = 1'b0;
        scrub_rd_o = 1'b0;
        case (state_q)
            SCRUB_IDLE: begin
                addr_d = '0;
                cnt_d  = '0;
                if (trigger_i) state_d = SCRUB_SCAN;
            end
            SCRUB_SCAN: begin
                // Steal depends only on registered state so the grant never
                // combinationally follows the request.
                steal      = (ScrubMaxWait != 0) && (cnt_q == CntMax);
                scrub_rd_o = !ram_req_i || steal;
                if (scrub_rd_o) begin
                    cnt_d  = '0;
                    addr_d = addr_q + 1'b1;
                    if (addr_q == '1) begin
                        state_d = SCRUB_IDLE;
                        addr_d  = '0;
                    end
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SCRUB_IDLE;
        endcase
    end

    assign gnt_o        = !steal;
    assign scrub_addr_o = addr_q;
    assign busy_o       = (state_q == SCRUB_SCAN);

endmodule

// File: rtl/axi_llc_data_sram_resp.sv
// SRAM responder for one LLC data way: single-port storage with byte-enabled
// writes, per-granule even parity, parity error injection and a scrubber.
module axi_llc_data_sram_resp
    import axi_llc_pkg::*;
#(
    parameter llc_cfg_t    Cfg          = LlcDefaultCfg,
    parameter int unsigned SramBankNum  = (Cfg.DataEccGranularity == 0) ? 1 :
                                          Cfg.BlockSize / Cfg.DataEccGranularity,
    parameter int unsigned ScrubMaxWait = 16,
    localparam int unsigned AW          = Cfg.IndexLength + Cfg.BlockOffsetLength,
    localparam int unsigned DW          = Cfg.BlockSize
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   ram_req_i,
    input  logic                   ram_we_i,
    input  logic [AW-1:0]          ram_addr_i,
    input  logic [DW-1:0]          ram_wdata_i,
    input  logic [DW/8-1:0]        ram_be_i,
    output logic                   ram_gnt_o,
    output logic [DW-1:0]          ram_data_o,
    output logic                   ram_data_multi_err_o,
    input  logic [SramBankNum-1:0] scrub_trigger_i,
    output logic                   scrub_busy_o,
    output logic [SramBankNum-1:0] scrub_uncorrectable_o,
    input  logic                   inj_valid_i,
    input  logic [AW-1:0]          inj_addr_i,
    input  logic [SramBankNum-1:0] inj_mask_i
);

    localparam int unsigned GW    = DW / SramBankNum;
    localparam int unsigned Depth = 2 ** AW;

    if (DataMacroLatency != 1) begin : gen_latency_check
        $error("axi_llc_data_sram_resp supports a data macro latency of 1 only");
    end
    if ((DW % SramBankNum) != 0 || (DW % 8) != 0) begin : gen_granule_check
        $error("block size must split evenly into bytes and parity granules");
    end

    function automatic logic [SramBankNum-1:0] word_parity(input logic [DW-1:0] w);
        logic [SramBankNum-1:0] p;
        p = '0;
        for (int g = 0; g < SramBankNum; g++) begin
            p[g] = granule_parity(MaxGranW'(w[g*GW +: GW]), GW);
        end
        return p;
    endfunction

    logic [DW-1:0]          mem_q [Depth];
    logic [SramBankNum-1:0] par_q [Depth];

    logic [DW-1:0]          bit_en, cur_word, merged;
    logic [SramBankNum-1:0] touched, wpar, inj_par_base;
    logic                   port_wr, port_rd;
    logic                   scrub_rd;
    logic [AW-1:0]          scrub_addr;

    logic [DW-1:0]          ram_data_p1;
    logic                   multi_err_p1;
    logic [SramBankNum-1:0] scrub_bad_p1;

    axi_llc_data_scrubber #(
        .AW           (AW),
        .ScrubMaxWait (ScrubMaxWait)
    ) i_scrubber (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .trigger_i    (|scrub_trigger_i),
        .ram_req_i    (ram_req_i),
        .gnt_o        (ram_gnt_o),
        .scrub_rd_o   (scrub_rd),
        .scrub_addr_o (scrub_addr),
        .busy_o       (scrub_busy_o)
    );

    // Byte merge and parity of the touched granules for a port write, plus the
    // parity base that an injection in the same cycle flips.
    always_comb begin
        bit_en  = '0;
        touched = '0;
        for (int i = 0; i < DW; i++) bit_en[i] = ram_be_i[i/8];
        cur_word = mem_q[ram_addr_i];
        merged   = (ram_wdata_i & bit_en) | (cur_word & ~bit_en);
        for (int g = 0; g < SramBankNum; g++) touched[g] = |bit_en[g*GW +: GW];
        wpar     = (word_parity(merged) & touched) | (par_q[ram_addr_i] & ~touched);
        port_wr  = ram_req_i && ram_gnt_o && ram_we_i;
        port_rd  = ram_req_i && ram_gnt_o && !ram_we_i;
        inj_par_base = (port_wr && (ram_addr_i == inj_addr_i)) ? wpar : par_q[inj_addr_i];
    end

    // Storage update: port write first, injection flips parity on top of it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int d = 0; d < Depth; d++) begin
                mem_q[d] <= '0;
                par_q[d] <= '0;
            end
        end else begin
            if (port_wr) begin
                mem_q[ram_addr_i] <= merged;
                par_q[ram_addr_i] <= wpar;
            end
            if (inj_valid_i) par_q[inj_addr_i] <= inj_par_base ^ inj_mask_i;
        end
    end

    // Stage p1: read data and parity check held until the next granted read;
    // scrubber mismatch pulses last exactly one cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ram_data_p1  <= '0;
            multi_err_p1 <= 1'b0;
            scrub_bad_p1 <= '0;
        end else begin
            if (port_rd) begin
                ram_data_p1  <= mem_q[ram_addr_i];
                multi_err_p1 <= |(par_q[ram_addr_i] ^ word_parity(mem_q[ram_addr_i]));
            end
            scrub_bad_p1 <= scrub_rd ? (par_q[scrub_addr] ^ word_parity(mem_q[scrub_addr])) : '0;
        end
    end

    assign ram_data_o            = ram_data_p1;
    assign ram_data_multi_err_o  = multi_err_p1;
    assign scrub_uncorrectable_o = scrub_bad_p1;

endmodule

// File: tb/tb_axi_llc_data_sram_resp.sv
// Directed bench for the LLC data-way SRAM responder (16 x 64-bit, 4 granules).
module tb_axi_llc_data_sram_resp;
    import axi_llc_pkg::*;

    localparam llc_cfg_t TbCfg = '{
        IndexLength:        32'd3,
        BlockOffsetLength:  32'd1,
        BlockSize:          32'd64,
        DataEccGranularity: 32'd16
    };

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        ram_req, ram_we;
    logic [3:0]  ram_addr;
    logic [63:0] ram_wdata;
    logic [7:0]  ram_be;
    logic        ram_gnt;
    logic [63:0] ram_data;
    logic        ram_err;
    logic [3:0]  scrub_trig;
    logic        scrub_busy;
    logic [3:0]  scrub_unc;
    logic        inj_valid;
    logic [3:0]  inj_addr;
    logic [3:0]  inj_mask;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_llc_data_sram_resp #(
        .Cfg          (TbCfg),
        .ScrubMaxWait (16)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_ni),
        .ram_req_i             (ram_req),
        .ram_we_i              (ram_we),
        .ram_addr_i            (ram_addr),
        .ram_wdata_i           (ram_wdata),
        .ram_be_i              (ram_be),
        .ram_gnt_o             (ram_gnt),
        .ram_data_o            (ram_data),
        .ram_data_multi_err_o  (ram_err),
        .scrub_trigger_i       (scrub_trig),
        .scrub_busy_o          (scrub_busy),
        .scrub_uncorrectable_o (scrub_unc),
        .inj_valid_i           (inj_valid),
        .inj_addr_i            (inj_addr),
        .inj_mask_i            (inj_mask)
    );

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        ram_req = 1'b0; ram_we = 1'b0; ram_be = '0; ram_wdata = '0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [63:0] d, input logic [7:0] b);
        ram_req = 1'b1; ram_we = 1'b1; ram_addr = a; ram_wdata = d; ram_be = b;
        tick();
        idle();
    endtask

    task automatic rd(input string name, input logic [3:0] a, input logic [63:0] ed, input logic ee);
        ram_req = 1'b1; ram_we = 1'b0; ram_addr = a;
        tick();
        idle();
        check({name, "_data"}, ram_data, ed);
        check({name, "_err"}, 64'(ram_err), 64'(ee));
    endtask

    task automatic inject(input logic [3:0] a, input logic [3:0] m);
        inj_valid = 1'b1; inj_addr = a; inj_mask = m;
        tick();
        inj_valid = 1'b0; inj_mask = '0;
    endtask

    initial begin
        int busy_cnt, pulse_cnt, pulse_cyc, end_cyc, low_cnt, first_low, prev_low, gap_bad, data_bad;
        logic [3:0] pulse_val;

        rst_ni = 1'b0; ram_req = 1'b0; ram_we = 1'b0; ram_addr = '0; ram_wdata = '0;
        ram_be = '0; scrub_trig = '0; inj_valid = 1'b0; inj_addr = '0; inj_mask = '0;
        tick();
        tick();
        check("rst_gnt", 64'(ram_gnt), 64'd1);
        check("rst_data", ram_data, 64'd0);
        check("rst_err", 64'(ram_err), 64'd0);
        check("rst_busy", 64'(scrub_busy), 64'd0);
        check("rst_unc", 64'(scrub_unc), 64'd0);
        rst_ni = 1'b1;

        // {we, addr, wdata, be, exp_data, exp_err}; expected only checked on reads
        vecs[0]  = '{1'b1, 4'd5,  64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, 4'd5,  64'h0, 8'h00, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0};
        vecs[2]  = '{1'b1, 4'd7,  64'h1122_3344_5566_7788, 8'h01, 64'h0, 1'b0};
        vecs[3]  = '{1'b0, 4'd7,  64'h0, 8'h00, 64'h0000_0000_0000_0088, 1'b0};
        vecs[4]  = '{1'b1, 4'd7,  64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 64'h0, 1'b0};
        vecs[5]  = '{1'b0, 4'd7,  64'h0, 8'h00, 64'hFFFF_FFFF_0000_0088, 1'b0};
        vecs[6]  = '{1'b0, 4'd0,  64'h0, 8'h00, 64'h0, 1'b0};
        vecs[7]  = '{1'b1, 4'd15, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 1'b0};
        vecs[8]  = '{1'b0, 4'd15, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[9]  = '{1'b1, 4'd15, 64'h0, 8'h0C, 64'h0, 1'b0};
        vecs[10] = '{1'b0, 4'd15, 64'h0, 8'h00, 64'h0123_4567_0000_CDEF, 1'b0};
        vecs[11] = '{1'b0, 4'd5,  64'h0, 8'h00, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0};

        for (int i = 0; i < 12; i++) begin
            ram_req = 1'b1; ram_we = vecs[i].we; ram_addr = vecs[i].addr;
            ram_wdata = vecs[i].wdata; ram_be = vecs[i].be;
            check($sformatf("vec%0d_gnt", i), 64'(ram_gnt), 64'd1);
            tick();
            if (!vecs[i].we) begin
                check($sformatf("vec%0d_data", i), ram_data, vecs[i].exp_data);
                check($sformatf("vec%0d_err", i), 64'(ram_err), 64'(vecs[i].exp_err));
            end
        end
        idle();

        // Read data holds across idle cycles and across a write
        rd("hold_rd", 4'd7, 64'hFFFF_FFFF_0000_0088, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ram_req = 1'b1; ram_we = 1'b1; ram_addr = 4'd7; ram_wdata = '0; ram_be = 8'hFF;
            end
            tick();
            idle();
            check($sformatf("hold%0d", i), ram_data, 64'hFFFF_FFFF_0000_0088);
        end
        rd("hold_after_wr", 4'd7, 64'h0, 1'b0);

        // Parity injection and repair by rewriting
        inject(4'd3, 4'b0001);
        rd("inj_rd", 4'd3, 64'h0, 1'b1);
        wr(4'd3, 64'h5555_5555_5555_5555, 8'hFF);
        rd("inj_fixed", 4'd3, 64'h5555_5555_5555_5555, 1'b0);
        inject(4'd3, 4'b0010);
        wr(4'd3, 64'h0000_0000_0000_0077, 8'h01);
        rd("inj_untouched", 4'd3, 64'h5555_5555_5555_5577, 1'b1);
        wr(4'd3, 64'h0, 8'h04);
        rd("inj_touched", 4'd3, 64'h5555_5555_5500_5577, 1'b0);

        // Injection in the same cycle as a write to the same address wins
        ram_req = 1'b1; ram_we = 1'b1; ram_addr = 4'd9;
        ram_wdata = 64'h0F0F_0F0F_0F0F_0F0F; ram_be = 8'hFF;
        inj_valid = 1'b1; inj_addr = 4'd9; inj_mask = 4'b0100;
        tick();
        idle(); inj_valid = 1'b0; inj_mask = '0;
        rd("inj_wr_same", 4'd9, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);

        // Scrub with idle port; retrigger during the scan is ignored
        scrub_trig = 4'b0001;
        tick();
        scrub_trig = '0;
        busy_cnt = 0; pulse_cnt = 0; pulse_cyc = -1; pulse_val = '0; end_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            if (scrub_busy) busy_cnt++;
            else if (end_cyc < 0) end_cyc = c;
            if (scrub_unc != '0) begin
                pulse_cnt++; pulse_cyc = c; pulse_val = scrub_unc;
            end
            scrub_trig = (c == 5) ? 4'b1000 : 4'b0000;
            tick();
        end
        scrub_trig = '0;
        check("scrub_busy_cycles", 64'(busy_cnt), 64'd16);
        check("scrub_end_cycle", 64'(end_cyc), 64'd16);
        check("scrub_pulse_count", 64'(pulse_cnt), 64'd1);
        check("scrub_pulse_value", 64'(pulse_val), 64'(4'b0100));
        check("scrub_pulse_cycle", 64'(pulse_cyc), 64'd10);

        // Continuous reads while scanning: one stolen grant every 17 cycles
        ram_req = 1'b1; ram_we = 1'b0; ram_addr = 4'd5;
        scrub_trig = 4'b0010;
        tick();
        scrub_trig = '0;
        low_cnt = 0; first_low = -1; prev_low = -1; gap_bad = 0; data_bad = 0;
        pulse_cnt = 0; end_cyc = -1;
        for (int c = 0; c < 400; c++) begin
            if (!scrub_busy && end_cyc < 0) end_cyc = c;
            if (ram_data !== 64'hAAAA_AAAA_AAAA_AAAA || ram_err !== 1'b0) data_bad++;
            if (scrub_unc != '0) pulse_cnt++;
            if (!ram_gnt) begin
                low_cnt++;
                if (first_low < 0) first_low = c;
                if (prev_low >= 0 && (c - prev_low) != 17) gap_bad++;
                prev_low = c;
            end
            if (end_cyc >= 0) break;
            tick();
        end
        idle();
        check("steal_first", 64'(first_low), 64'd16);
        check("steal_count", 64'(low_cnt), 64'd16);
        check("steal_gaps", 64'(gap_bad), 64'd0);
        check("steal_scan_end", 64'(end_cyc), 64'd272);
        check("steal_rd_data", 64'(data_bad), 64'd0);
        check("steal_pulses", 64'(pulse_cnt), 64'd1);

        // Reset while the scrubber reads the corrupt address
        scrub_trig = 4'b0100;
        tick();
        scrub_trig = '0;
        for (int c = 0; c < 9; c++) tick();
        check("midscan_busy", 64'(scrub_busy), 64'd1);
        rst_ni = 1'b0;
        tick();
        check("midrst_gnt", 64'(ram_gnt), 64'd1);
        check("midrst_data", ram_data, 64'd0);
        check("midrst_err", 64'(ram_err), 64'd0);
        check("midrst_busy", 64'(scrub_busy), 64'd0);
        check("midrst_unc", 64'(scrub_unc), 64'd0);
        rst_ni = 1'b1;
        busy_cnt = 0; pulse_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (scrub_busy) busy_cnt++;
            if (scrub_unc != '0) pulse_cnt++;
            tick();
        end
        check("postrst_busy", 64'(busy_cnt), 64'd0);
        check("postrst_pulses", 64'(pulse_cnt), 64'd0);
        rd("postrst_rd", 4'd5, 64'h0, 1'b0);
        rd("postrst_rd9", 4'd9, 64'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
